// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0]  TUSE_NONE    = 2'd3;
    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;
    localparam int          MULT_CYC_DEF = 5;
    localparam int          DIV_CYC_DEF  = 10;

    // One source operand stalls when a pending producer delivers later than D needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        return (src != REG_ZERO) && (tuse != TUSE_NONE) &&
               (((src == e_a3) && (tuse < e_tnew)) || ((src == m_a3) && (tuse < m_tnew)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_timer.sv
// Countdown of the multiply/divide unit's busy window after an operation starts in E.
module mdu_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             mdu_start,
    input  logic             mdu_div,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // A start in a flushed E stage is dropped; an operation already running finishes.
    always_comb begin
        cnt_next = cnt_reg;
        if (!req && mdu_start)
            cnt_next = mdu_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        else if (cnt_reg != '0)
            cnt_next = cnt_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign mdu_busy = reset & (mdu_start | (cnt_reg != '0));
    assign cnt      = cnt_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler: data, MDU and eret hazards, exception priority, stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_mdu,
    input  logic        D_eret,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        E_mdu_start,
    input  logic        E_mdu_div,
    input  logic        E_mtc0_epc,
    input  logic        M_mtc0_epc,
    output logic        F_WE,
    output logic        D_WE,
    output logic        E_clr,
    output logic        stall,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles
);

    logic [4:0]       src_reg  [2];
    logic [1:0]       src_tuse [2];
    logic [1:0]       src_stall;
    logic [CNT_W-1:0] mdu_cnt;
    logic             stall_mdu;
    logic             stall_eret;
    logic             stall_raw;
    logic [31:0]      stall_cycles_reg;

    assign src_reg[0]  = D_rs;
    assign src_reg[1]  = D_rt;
    assign src_tuse[0] = D_Tuse_rs;
    assign src_tuse[1] = D_Tuse_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_stall[gi] = src_hazard(src_reg[gi], src_tuse[gi],
                                              E_A3, E_Tnew, M_A3, M_Tnew);
        end
    endgenerate

    mdu_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_mdu_busy_timer (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mdu_start (E_mdu_start),
        .mdu_div   (E_mdu_div),
        .mdu_busy  (mdu_busy),
        .cnt       (mdu_cnt)
    );

    assign stall_mdu  = D_is_mdu & (E_mdu_start | (mdu_cnt != '0));
    assign stall_eret = D_eret & (E_mtc0_epc | M_mtc0_epc);
    assign stall_raw  = (|src_stall) | stall_mdu | stall_eret;

    // Held reset presents the no-hazard state on every output.
    assign stall = reset & stall_raw;

    // The exception flush overrides any stall; the pipeline regs clear themselves on req.
    assign F_WE  = req | ~stall;
    assign D_WE  = req | ~stall;
    assign E_clr = ~req & stall;

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cycles_reg <= '0;
        else if (stall && !req)
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end

    assign stall_cycles = stall_cycles_reg;

endmodule
